// File: rtl/mem_access_stage.sv
// MEM pipeline stage with the MEM/WB register: drives a handshaked data-memory port,
// stalls upstream while an access is outstanding, and aborts accesses that time out.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res,
  input  logic [31:0] data2,
  input  logic [4:0]  rd,
  input  logic [2:0]  mem_ctrl,
  input  logic        wb_ctrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_en,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_LH  = 3'b111;

  // The counter value of the final permitted wait cycle; the entry cycle in IDLE is cycle 1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        is_access, is_store, misaligned, abort;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign is_access = (mem_ctrl != 3'b000);
  assign is_store  = mem_ctrl[2] && (mem_ctrl != OP_LH);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    misaligned = 1'b0;
    case (mem_ctrl)
      OP_LW, OP_SW: misaligned = |alu_res[1:0];
      OP_LH, OP_SH: misaligned = alu_res[0];
      default:      misaligned = 1'b0;
    endcase
  end

  assign dmem_req  = is_access && !misaligned;
  assign dmem_we   = dmem_req && is_store;
  assign dmem_addr = {alu_res[31:2], 2'b00};

  // Abort is taken only when ready is absent, so a late ready always wins.
  assign abort     = dmem_req && !dmem_ready &&
                     ((state == ST_WAIT) ? (cnt >= CNT_LAST) : (TIMEOUT == 1));
  assign mem_stall = dmem_req && !dmem_ready && !abort;

  always_comb begin
    dmem_wdata = data2;
    dmem_wstrb = 4'b0000;
    case (mem_ctrl)
      OP_SB: begin
        dmem_wdata = {4{data2[7:0]}};
        dmem_wstrb = 4'b0001 << alu_res[1:0];
      end
      OP_SH: begin
        dmem_wdata = {2{data2[15:0]}};
        dmem_wstrb = alu_res[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW:   dmem_wstrb = 4'b1111;
      default: dmem_wstrb = 4'b0000;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (alu_res[1:0])
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = alu_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (mem_ctrl)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LW:   ld_data = dmem_rdata;
      default: ld_data = alu_res;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (mem_stall) begin
          state_n = ST_WAIT;
          cnt_n   = 8'd1;
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          cnt_n = cnt + 8'd1;
        end else begin
          state_n = ST_IDLE;
          cnt_n   = 8'd0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data      <= 32'd0;
      wb_rd        <= 5'd0;
      wb_en        <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      misalign_err <= is_access && misaligned;
      timeout_err  <= abort;
      if (mem_stall) begin
        wb_en <= 1'b0;
      end else begin
        wb_data <= ld_data;
        wb_rd   <= rd;
        wb_en   <= wb_ctrl && (rd != 5'd0) && !misaligned && !abort;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT = 4): alignment, lane handling,
// wait states, timeout versus late ready, and asynchronous reset during a wait.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_res, data2, dmem_rdata;
  logic [4:0]  rd;
  logic [2:0]  mem_ctrl;
  logic        wb_ctrl, dmem_ready;
  logic        dmem_req, dmem_we, mem_stall, wb_en, misalign_err, timeout_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .alu_res(alu_res), .data2(data2), .rd(rd),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a new input vector just after a rising edge; checks follow 1 ns later.
  task automatic drive(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] dst, input logic wbc, input logic rdy,
                       input logic [31:0] rdata);
    mem_ctrl = ctrl; alu_res = addr; data2 = wd; rd = dst;
    wb_ctrl = wbc; dmem_ready = rdy; dmem_rdata = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    #12;
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Zero-wait LW
    drive(3'b001, 32'h100, 32'd0, 5'd5, 1'b1, 1'b1, 32'hDEADBEEF);
    check("lw_req", 32'(dmem_req), 32'd1);
    check("lw_stall", 32'(mem_stall), 32'd0);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_we_strb", {27'd0, dmem_we, dmem_wstrb}, 32'd0);
    tick();
    check("lw_wb_data", wb_data, 32'hDEADBEEF);
    check("lw_wb_rd", 32'(wb_rd), 32'd5);
    check("lw_wb_en", 32'(wb_en), 32'd1);

    // LB then LBU back-to-back at lane 3
    drive(3'b010, 32'h103, 32'd0, 5'd6, 1'b1, 1'b1, 32'h80FF0000);
    tick();
    check("lb_wb_data", wb_data, 32'hFFFFFF80);
    drive(3'b011, 32'h103, 32'd0, 5'd6, 1'b1, 1'b1, 32'h80FF0000);
    tick();
    check("lbu_wb_data", wb_data, 32'h00000080);

    // LH upper half, sign-extended
    drive(3'b111, 32'h102, 32'd0, 5'd9, 1'b1, 1'b1, 32'h80011234);
    tick();
    check("lh_wb_data", wb_data, 32'hFFFF8001);

    // SH upper half
    drive(3'b110, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1'b1, 32'd0);
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    check("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    check("sh_we", 32'(dmem_we), 32'd1);
    tick();
    check("sh_wb_en", 32'(wb_en), 32'd0);

    // SB lane 1
    drive(3'b101, 32'h301, 32'h000000A5, 5'd0, 1'b0, 1'b1, 32'd0);
    check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    check("sb_wstrb", 32'(dmem_wstrb), 32'h2);
    tick();

    // ALU-only op sets wb_en so the following stall bubble is visible
    drive(3'b000, 32'h0000_0042, 32'd0, 5'd3, 1'b1, 1'b1, 32'd0);
    check("alu_req", 32'(dmem_req), 32'd0);
    tick();
    check("alu_wb_data", wb_data, 32'h42);
    check("alu_wb_en", 32'(wb_en), 32'd1);

    // LW with three wait cycles
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 32'h300, 32'd0, 5'd7, 1'b1, 1'b0, 32'd0);
      check($sformatf("wait_stall%0d", i), 32'(mem_stall), 32'd1);
      tick();
      check($sformatf("wait_wb_en%0d", i), 32'(wb_en), 32'd0);
      check($sformatf("wait_wb_hold%0d", i), wb_data, 32'h42);
    end
    drive(3'b001, 32'h300, 32'd0, 5'd7, 1'b1, 1'b1, 32'h11223344);
    check("wait_done_stall", 32'(mem_stall), 32'd0);
    tick();
    check("wait_wb_data", wb_data, 32'h11223344);
    check("wait_wb_en", 32'(wb_en), 32'd1);

    // LW that never gets ready: 3 stall cycles, then abort
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 32'h400, 32'd0, 5'd8, 1'b1, 1'b0, 32'd0);
      check($sformatf("to_stall%0d", i), 32'(mem_stall), 32'd1);
      check($sformatf("to_err_low%0d", i), 32'(timeout_err), 32'd0);
      tick();
    end
    drive(3'b001, 32'h400, 32'd0, 5'd8, 1'b1, 1'b0, 32'd0);
    check("to_abort_stall", 32'(mem_stall), 32'd0);
    check("to_abort_req", 32'(dmem_req), 32'd1);
    tick();
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_wb_en", 32'(wb_en), 32'd0);
    drive(3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0);
    check("to_req_after", 32'(dmem_req), 32'd0);
    tick();
    check("to_err_pulse", 32'(timeout_err), 32'd0);

    // Same access with ready on the 4th cycle: ready wins over timeout
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 32'h404, 32'd0, 5'd8, 1'b1, 1'b0, 32'd0);
      tick();
    end
    drive(3'b001, 32'h404, 32'd0, 5'd8, 1'b1, 1'b1, 32'hCAFEF00D);
    check("late_stall", 32'(mem_stall), 32'd0);
    tick();
    check("late_no_err", 32'(timeout_err), 32'd0);
    check("late_wb_data", wb_data, 32'hCAFEF00D);
    check("late_wb_en", 32'(wb_en), 32'd1);

    // Misaligned SW
    drive(3'b100, 32'h101, 32'h55, 5'd4, 1'b1, 1'b1, 32'd0);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_stall", 32'(mem_stall), 32'd0);
    tick();
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_wb_en", 32'(wb_en), 32'd0);
    drive(3'b000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0);
    tick();
    check("mis_err_pulse", 32'(misalign_err), 32'd0);

    // Reset asserted during WAIT
    drive(3'b000, 32'h77, 32'd0, 5'd2, 1'b1, 1'b0, 32'd0);
    tick();
    drive(3'b001, 32'h500, 32'd0, 5'd2, 1'b1, 1'b0, 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstw_wb_data", wb_data, 32'd0);
    check("rstw_wb_rd", 32'(wb_rd), 32'd0);
    check("rstw_wb_en", 32'(wb_en), 32'd0);
    check("rstw_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    mem_ctrl = 3'b000;
    #1;
    check("rstw_req", 32'(dmem_req), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    drive(3'b001, 32'h600, 32'd0, 5'd1, 1'b1, 1'b1, 32'h0BADF00D);
    tick();
    check("post_rst_wb", wb_data, 32'h0BADF00D);
    check("post_rst_no_err", 32'(timeout_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
